// File: rtl/lock_pkg.sv
// Shared state encoding and widths for the lock controller.
// Code 3'b011 is deliberately left unused.
package lock_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned WRONG_W = 4;

    localparam logic [STATE_W-1:0] ST_OFF    = 3'b000;
    localparam logic [STATE_W-1:0] ST_ON     = 3'b001;
    localparam logic [STATE_W-1:0] ST_WRONG  = 3'b010;
    localparam logic [STATE_W-1:0] ST_ANSWER = 3'b100;
    localparam logic [STATE_W-1:0] ST_RESET  = 3'b101;
    localparam logic [STATE_W-1:0] ST_LOCK   = 3'b111;

    typedef enum logic [STATE_W-1:0] {
        StOff    = ST_OFF,
        StOn     = ST_ON,
        StWrong  = ST_WRONG,
        StAnswer = ST_ANSWER,
        StReset  = ST_RESET,
        StLock   = ST_LOCK
    } lock_state_e;

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector for a key level; one-cycle pulse per press.
// History resets to RST_VAL so a key held through reset can be made silent.
module key_edge_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= RST_VAL;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/lock_state_controller.sv
// Door-lock sequencer: retry limit, self-releasing lockout, auto-relock after a
// correct entry and password-change handshake. All outputs are registered.
module lock_state_controller
    import lock_pkg::*;
#(
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1000,
    parameter int unsigned OPEN_CYCLES    = 500,
    parameter int unsigned CNT_W          = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               is_on,
    input  logic               star_key,
    input  logic               reset_key,
    input  logic               correct,
    input  logic               init_key,
    output logic [STATE_W-1:0] state,
    output logic [WRONG_W-1:0] wrong_cnt,
    output logic [CNT_W-1:0]   lock_remaining,
    output logic               door_open,
    output logic               alarm,
    output logic               pw_commit,
    output logic               pw_reject
);

    localparam logic [WRONG_W:0]   MAX_EXT   = (WRONG_W + 1)'(MAX_TRIES);
    localparam logic [WRONG_W-1:0] MAX_CNT   = WRONG_W'(MAX_TRIES);
    localparam logic [CNT_W-1:0]   LOCK_INIT = CNT_W'(LOCKOUT_CYCLES);
    localparam logic [CNT_W-1:0]   OPEN_INIT = CNT_W'(OPEN_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

    lock_state_e        state_q, state_d;
    logic [WRONG_W-1:0] wrong_q, wrong_d;
    logic [CNT_W-1:0]   lock_q, lock_d;
    logic [CNT_W-1:0]   open_q, open_d;
    logic               door_q, alarm_q, commit_q, reject_q;
    logic               commit_d, reject_d;
    logic               star_ev, reset_ev;
    logic [WRONG_W:0]   wrong_inc;
    logic               powered_state;

    key_edge_detect #(
        .RST_VAL (1'b1)
    ) u_star_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level (star_key),
        .rise  (star_ev)
    );

    key_edge_detect #(
        .RST_VAL (1'b1)
    ) u_reset_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level (reset_key),
        .rise  (reset_ev)
    );

    // Extra bit so the compare cannot wrap when MAX_TRIES is 15.
    assign wrong_inc = {1'b0, wrong_q} + 1'b1;

    assign powered_state = (state_q == StOn) || (state_q == StWrong) ||
                           (state_q == StAnswer) || (state_q == StReset);

    always_comb begin
        state_d  = state_q;
        wrong_d  = wrong_q;
        lock_d   = lock_q;
        open_d   = open_q;
        commit_d = 1'b0;
        reject_d = 1'b0;

        if (init_key) begin
            state_d = StOff;
            wrong_d = '0;
            lock_d  = '0;
            open_d  = '0;
        end else if (!is_on && powered_state) begin
            // Strikes survive a power cycle.
            state_d = StOff;
            open_d  = '0;
        end else begin
            unique case (state_q)
                StOff: begin
                    if (is_on) begin
                        state_d = StOn;
                    end
                end
                StOn, StWrong: begin
                    if (star_ev) begin
                        if (correct) begin
                            state_d = StAnswer;
                            wrong_d = '0;
                            open_d  = OPEN_INIT;
                        end else if (wrong_inc >= MAX_EXT) begin
                            state_d = StLock;
                            wrong_d = MAX_CNT;
                            lock_d  = LOCK_INIT;
                        end else begin
                            state_d = StWrong;
                            wrong_d = wrong_inc[WRONG_W-1:0];
                        end
                    end
                end
                StAnswer: begin
                    if (reset_ev) begin
                        state_d = StReset;
                        open_d  = '0;
                    end else if (OPEN_CYCLES != 0) begin
                        if (open_q <= CNT_ONE) begin
                            state_d = StOn;
                            open_d  = '0;
                        end else begin
                            open_d = open_q - CNT_ONE;
                        end
                    end
                end
                StReset: begin
                    if (star_ev) begin
                        if (correct) begin
                            state_d  = StOff;
                            commit_d = 1'b1;
                        end else begin
                            reject_d = 1'b1;
                        end
                    end
                end
                StLock: begin
                    if (lock_q <= CNT_ONE) begin
                        state_d = StOff;
                        wrong_d = '0;
                        lock_d  = '0;
                    end else begin
                        lock_d = lock_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = StOff;
                    lock_d  = '0;
                    open_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StOff;
            wrong_q  <= '0;
            lock_q   <= '0;
            open_q   <= '0;
            door_q   <= 1'b0;
            alarm_q  <= 1'b0;
            commit_q <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wrong_q  <= wrong_d;
            lock_q   <= lock_d;
            open_q   <= open_d;
            door_q   <= (state_d == StAnswer);
            alarm_q  <= (state_d == StLock);
            commit_q <= commit_d;
            reject_q <= reject_d;
        end
    end

    assign state          = state_q;
    assign wrong_cnt      = wrong_q;
    assign lock_remaining = lock_q;
    assign door_open      = door_q;
    assign alarm          = alarm_q;
    assign pw_commit      = commit_q;
    assign pw_reject      = reject_q;

endmodule

// File: doc/lock_state_controller.md
Name: lock_state_controller

Overview:
- Clocked, parametrised successor to the door-lock state manager.
- Sequences the lock through OFF / ON / WRONG / ANSWER / RESET / LOCK from keypad-level inputs.
- Adds a configurable retry limit, a timed lockout that releases itself, an auto-relock timeout after a correct entry, and edge-detected key events.
- Sits between the keypad/password-compare logic and the door actuator / display drivers.

Parameters:
- MAX_TRIES, 3, wrong '*' submissions that trigger LOCK (1..15)
- LOCKOUT_CYCLES, 1000, cycles spent in LOCK before automatic release (1..2^CNT_W-1)
- OPEN_CYCLES, 500, cycles in ANSWER before auto-relock to ON; 0 disables the timeout
- CNT_W, 16, width of the internal timers

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- is_on  in  1  power/toggle level from keypad '#' latch
- star_key  in  1  '*' key level; the event is its rising edge
- reset_key  in  1  password-change key level; the event is its rising edge
- correct  in  1  level from the compare block; means "entry matches" in ON/WRONG and "new password valid" in RESET
- init_key  in  1  factory-initialise level
- state  out  3  current state code
- wrong_cnt  out  4  consecutive wrong submissions
- lock_remaining  out  CNT_W  lockout cycles left; 0 outside LOCK
- door_open  out  1  high while state==ANSWER
- alarm  out  1  high while state==LOCK
- pw_commit  out  1  one-cycle pulse when a new password is accepted
- pw_reject  out  1  one-cycle pulse when a new password is refused

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - state=OFF, wrong_cnt=0, lock_remaining=0, open timer=0, door_open=0, alarm=0, pw_commit=0, pw_reject=0.
  - Edge-detector history registers reset to 1, so a key held through reset release produces no event.
- State codes: OFF=000, ON=001, WRONG=010, ANSWER=100, RESET=101, LOCK=111. Code 011 is unused; if ever reached, go to OFF next cycle.
- Events: star_ev = star_key & ~star_q, and reset_ev likewise; each is one cycle wide. is_on and init_key act as levels.
- Priority per cycle, highest first:
  - init_key=1: OFF, wrong_cnt=0, timers cleared.
  - is_on=0 in ON/WRONG/ANSWER/RESET: OFF. wrong_cnt is kept, so power-cycling does not clear strikes.
  - State-specific transitions below.
- OFF: is_on=1 -> ON.
- ON/WRONG with star_ev:
  - correct=1 -> ANSWER; wrong_cnt=0; open timer loads OPEN_CYCLES.
  - correct=0 and wrong_cnt+1==MAX_TRIES -> LOCK; wrong_cnt=MAX_TRIES; lock_remaining loads LOCKOUT_CYCLES.
  - correct=0 otherwise -> WRONG; wrong_cnt increments.
- LOCK:
  - is_on is ignored.
  - lock_remaining decrements each cycle. The cycle it is 1, next state=OFF with wrong_cnt=0 and lock_remaining=0.
  - Total dwell is exactly LOCKOUT_CYCLES cycles.
  - star_ev and reset_ev are ignored. init_key still overrides.
- ANSWER:
  - reset_ev -> RESET, open timer cleared.
  - Else, if OPEN_CYCLES>0, the timer decrements; the cycle it is 1, next state=ON.
  - star_ev is ignored.
- RESET with star_ev:
  - correct=1 -> OFF with pw_commit=1 for the next cycle.
  - correct=0 -> stay in RESET with pw_reject=1 for the next cycle.
- Simultaneous events:
  - star_ev and reset_ev in ON/WRONG: star wins.
  - star_ev and reset_ev in ANSWER: reset wins.
- Outputs:
  - door_open and alarm are registered decodes of the next state, so they align with state.
  - All outputs are registered. There is one cycle of latency from input edge to state change.
- wrong_cnt saturates at MAX_TRIES and never wraps.

Decomposition:
- Shared package lock_pkg holds:
  - state code localparams ST_OFF, ST_ON, ST_WRONG, ST_ANSWER, ST_RESET, ST_LOCK
  - state width STATE_W=3
  - the wrong_cnt width
- One sub-module, key_edge_detect:
  - parameter RST_VAL; ports clk, rst_n, level, rise
  - instantiated for star_key and reset_key.

Test Plan:
- Reset with star_key held high, then release rst_n -> no star_ev; state=000; all outputs 0.
- is_on=1; star with correct=0 twice, then with correct=1 -> state 001→010→010→100; wrong_cnt 1,2 then 0; door_open=1.
- MAX_TRIES=3, LOCKOUT_CYCLES=8; three wrong stars -> state=111, alarm=1, lock_remaining=8. Dwell exactly 8 cycles, then state=000 and wrong_cnt=0. is_on toggled during LOCK has no effect.
- From ANSWER, hold no keys with OPEN_CYCLES=5 -> back to 001 after exactly 5 cycles. Repeat with reset_ev at cycle 2 -> 101, and the timer does not fire.
- In RESET: star with correct=0 -> pw_reject pulse, state stays 101. Then star with correct=1 -> pw_commit 1-cycle pulse, state=000.
- init_key=1 asserted in LOCK with lock_remaining=5, and again in WRONG with wrong_cnt=2 -> next cycle state=000, wrong_cnt=0, lock_remaining=0. Also assert rst_n low mid-ANSWER -> immediate (asynchronous) return to 000 with door_open=0.
